tx_frame_arbiter: RTL and testbench

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

---
 rtl/tx_arb_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/tx_frame_arbiter.sv | 138 +++++++++++++
 tb/tb_tx_frame_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - state type and default timing constants for the TX frame arbiter
package tx_arb_pkg;

  typedef enum logic [1:0] {
    S_BLOCKED = 2'd0,
    S_IDLE    = 2'd1,
    S_GRANT   = 2'd2,
    S_GAP     = 2'd3
  } tx_arb_state_t;

  localparam int TX_ARB_IFG_DEFAULT       = 12;
  localparam int TX_ARB_MAX_FRAME_DEFAULT = 4096;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner search starting after last_idx
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  int cand;

  // Walk from farthest to nearest so the nearest pending requester overwrites the rest.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_idx) + k) % NUM_REQ;
      if (req[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - round-robin TX MAC arbiter with inter-frame gap and link blocking
// Optional per-grant watchdog is compiled in with TX_ARB_WATCHDOG_EN.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int IFG_CYCLES       = TX_ARB_IFG_DEFAULT,
  parameter int MAX_FRAME_CYCLES = TX_ARB_MAX_FRAME_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  input  logic                       tx_link_up,
  input  logic                       tx_changing,
  input  logic                       tx_reset,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       busy,
  output logic                       abort
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(IFG_CYCLES + 1);
  localparam logic [CNT_W-1:0] IFG_LOAD  = CNT_W'(IFG_CYCLES);
  localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_REQ - 1);

  tx_arb_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, pick_idx;
  logic             blocked_q, abort_d, pick_valid, done_hit, wd_expired;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (req),
    .last_idx (idx_q),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  assign done_hit = done[idx_q];

`ifdef TX_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_FRAME_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_FRAME_CYCLES - 1);
  logic [WD_W-1:0] wd_q;

  // Counts cycles already spent in the current grant; zero on the first granted cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (state_q == S_GRANT && state_d == S_GRANT) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  assign wd_expired = (wd_q == WD_LAST);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_BLOCKED;
      cnt_q     <= '0;
      idx_q     <= IDX_RESET;
      abort     <= 1'b0;
      blocked_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      abort     <= abort_d;
      blocked_q <= tx_reset | tx_changing | ~tx_link_up;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    abort_d = 1'b0;
    case (state_q)
      S_BLOCKED: begin
        if (!blocked_q) begin
          state_d = S_GAP;
          cnt_d   = IFG_LOAD;
        end
      end
      S_IDLE: begin
        if (blocked_q) begin
          state_d = S_BLOCKED;
        end else if (pick_valid) begin
          state_d = S_GRANT;
          idx_d   = pick_idx;
        end
      end
      S_GRANT: begin
        // A frame that finishes as the link drops is not an abort.
        if (blocked_q) begin
          state_d = S_BLOCKED;
          cnt_d   = '0;
          abort_d = ~done_hit;
        end else if (done_hit) begin
          state_d = S_GAP;
          cnt_d   = IFG_LOAD;
        end else if (wd_expired) begin
          state_d = S_GAP;
          cnt_d   = IFG_LOAD;
          abort_d = 1'b1;
        end
      end
      S_GAP: begin
        if (blocked_q) begin
          state_d = S_BLOCKED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_BLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  assign grant     = (state_q == S_GRANT) ? (NUM_REQ'(1) << idx_q) : '0;
  assign grant_idx = idx_q;
  assign busy      = |grant;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - self-checking bench for tx_frame_arbiter (directed + random vs model)
// Watchdog scenarios are selected by TX_ARB_WATCHDOG_EN.
module tb_tx_frame_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IW      = $clog2(NUM_REQ);
  localparam int IFG     = 12;
  localparam int MAXF    = 64;
`ifdef TX_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_REQ-1:0] req, done;
  logic               tx_link_up, tx_changing, tx_reset;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               busy, abort;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who owns the MAC, who won last, and the first cycle a new pick is allowed.
  int m_owner, m_last, m_pick_at, m_age, m_cycle;
  bit m_blocked, m_blk_reg, m_abort;

  always #5 clk = ~clk;

  tx_frame_arbiter #(
    .NUM_REQ          (NUM_REQ),
    .IFG_CYCLES       (IFG),
    .MAX_FRAME_CYCLES (MAXF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .tx_link_up  (tx_link_up),
    .tx_changing (tx_changing),
    .tx_reset    (tx_reset),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .abort       (abort)
  );

  task automatic model_release();
    m_owner   = -1;
    m_pick_at = m_cycle + IFG + 2;
  endtask

  // Advance the model by the inputs of this cycle, then clock the DUT and sample just after the edge.
  task automatic step();
    bit raw_blk;
    bit found;
    int c;
    raw_blk = tx_reset | tx_changing | ~tx_link_up;
    m_abort = 1'b0;
    if (!reset_n) begin
      m_owner = -1; m_last = NUM_REQ - 1; m_blocked = 1'b1; m_blk_reg = 1'b1; m_age = 0;
    end else begin
      if (m_blocked) begin
        if (!m_blk_reg) begin
          m_blocked = 1'b0;
          m_pick_at = m_cycle + IFG + 2;
        end
      end else if (m_blk_reg) begin
        m_abort   = (m_owner >= 0) && !done[m_owner];
        m_owner   = -1;
        m_blocked = 1'b1;
      end else if (m_owner >= 0) begin
        m_age++;
        if (done[m_owner]) begin
          model_release();
        end else if (WD_ON && m_age == MAXF) begin
          m_abort = 1'b1;
          model_release();
        end
      end else if (m_cycle >= m_pick_at && req != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (!found && req[c]) begin
            found   = 1'b1;
            m_owner = c;
          end
        end
        m_last = m_owner;
        m_age  = 0;
      end
      m_blk_reg = raw_blk;
    end
    @(posedge clk);
    #1;
    m_cycle++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; done = '0;
    tx_link_up = 1'b1; tx_changing = 1'b0; tx_reset = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output bit ok, output int steps);
    ok = 1'b0;
    steps = 0;
    while (!ok && steps < budget) begin
      step();
      steps++;
      if (grant != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 2'b11; done = '0;
    tx_link_up = 1'b1; tx_changing = 1'b0; tx_reset = 1'b0;
    step();
    step();
    n_total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort); else n_pass++;
    n_total++; if (grant_idx !== IW'(NUM_REQ - 1)) $display("FAIL reset_idx: got %0d want %0d", grant_idx, NUM_REQ - 1); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_alternate();
    bit ok; int steps, low, bad;
    logic [NUM_REQ-1:0] exp;
    do_reset();
    req = 2'b11;
    wait_grant(100, ok, steps);
    n_total++; if (!ok) $display("FAIL alt_first: no grant within 100 cycles"); else n_pass++;
    for (int g = 0; g < 4; g++) begin
      exp = (g % 2 == 0) ? 2'b01 : 2'b10;
      n_total++;
      if (grant !== exp || grant_idx !== IW'(g % 2))
        $display("FAIL alt_grant%0d: got %b idx %0d want %b idx %0d", g, grant, grant_idx, exp, g % 2);
      else n_pass++;
      bad = 0;
      repeat (20) begin
        step();
        if (grant !== exp) bad++;
      end
      n_total++; if (bad != 0) $display("FAIL alt_hold%0d: %0d cycles lost grant, want 0", g, bad); else n_pass++;
      done = exp;
      step();
      done = '0;
      if (g < 3) begin
        low = 0;
        while (grant == '0 && low < 100) begin
          low++;
          step();
        end
        n_total++; if (low != IFG + 2) $display("FAIL alt_gap%0d: %0d idle cycles, want %0d", g, low, IFG + 2); else n_pass++;
      end
    end
    req = '0;
  endtask

  task automatic test_abort_change();
    bit ok; int steps;
    do_reset();
    req = 2'b10;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || grant !== 2'b10) $display("FAIL chg_grant: got %b want 10", grant); else n_pass++;
    repeat (5) step();
    tx_changing = 1'b1;
    step();
    n_total++; if (grant !== 2'b10 || abort !== 1'b0) $display("FAIL chg_sample: grant %b abort %b want 10/0", grant, abort); else n_pass++;
    step();
    n_total++; if (grant !== 2'b00 || abort !== 1'b1) $display("FAIL chg_abort: grant %b abort %b want 00/1", grant, abort); else n_pass++;
    step();
    n_total++; if (abort !== 1'b0) $display("FAIL chg_pulse: abort %b want 0", abort); else n_pass++;
    repeat (3) step();
    tx_changing = 1'b0;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || steps != IFG + 4) $display("FAIL chg_regrant: %0d cycles, want %0d", steps, IFG + 4); else n_pass++;
    req = '0;
  endtask

  task automatic test_done_linkdown();
    bit ok; int steps, bad;
    do_reset();
    req = 2'b10;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || grant !== 2'b10) $display("FAIL dl_grant: got %b want 10", grant); else n_pass++;
    repeat (3) step();
    tx_link_up = 1'b0;
    step();
    done = 2'b10;
    step();
    done = '0;
    n_total++; if (grant !== 2'b00 || abort !== 1'b0) $display("FAIL dl_same: grant %b abort %b want 00/0", grant, abort); else n_pass++;
    bad = 0;
    repeat (30) begin
      step();
      if (grant !== 2'b00 || abort !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL dl_blocked: %0d bad cycles, want 0", bad); else n_pass++;
    tx_link_up = 1'b1;
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    bit ok; int steps;
    do_reset();
    req = 2'b11;
    wait_grant(100, ok, steps);
    repeat (4) step();
    done = 2'b01;
    step();
    done = '0;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || grant !== 2'b10) $display("FAIL rst_second: got %b want 10", grant); else n_pass++;
    repeat (5) step();
    reset_n = 1'b0;
    step();
    n_total++;
    if (grant !== 2'b00 || abort !== 1'b0 || grant_idx !== IW'(NUM_REQ - 1))
      $display("FAIL rst_mid: grant %b abort %b idx %0d want 00/0/%0d", grant, abort, grant_idx, NUM_REQ - 1);
    else n_pass++;
    reset_n = 1'b1;
    step();
    n_total++; if (abort !== 1'b0) $display("FAIL rst_abort: abort %b want 0", abort); else n_pass++;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || grant !== 2'b01 || grant_idx !== IW'(0)) $display("FAIL rst_first: grant %b idx %0d want 01/0", grant, grant_idx); else n_pass++;
    req = '0;
  endtask

  task automatic test_rr_handoff();
    bit ok; int steps;
    do_reset();
    req = 2'b01;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || grant !== 2'b01) $display("FAIL rr_first: got %b want 01", grant); else n_pass++;
    repeat (3) step();
    done = 2'b01;
    req  = 2'b11;
    step();
    done = '0;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || grant !== 2'b10) $display("FAIL rr_next: got %b want 10", grant); else n_pass++;
    req = '0;
  endtask

`ifdef TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok; int steps, hi;
    do_reset();
    req = 2'b01;
    wait_grant(100, ok, steps);
    hi = 1;
    while (grant != '0 && hi < 200) begin
      step();
      if (grant != '0) hi++;
    end
    n_total++; if (hi != MAXF) $display("FAIL wd_len: held %0d cycles, want %0d", hi, MAXF); else n_pass++;
    n_total++; if (abort !== 1'b1) $display("FAIL wd_abort: abort %b want 1", abort); else n_pass++;
    step();
    n_total++; if (abort !== 1'b0) $display("FAIL wd_pulse: abort %b want 0", abort); else n_pass++;
    wait_grant(100, ok, steps);
    n_total++; if (!ok || steps != IFG + 1) $display("FAIL wd_gap: %0d cycles, want %0d", steps, IFG + 1); else n_pass++;
    req = '0;
  endtask
`else
  task automatic test_no_watchdog();
    bit ok; int steps, bad;
    do_reset();
    req = 2'b01;
    wait_grant(100, ok, steps);
    bad = 0;
    repeat (150) begin
      step();
      if (grant !== 2'b01 || abort !== 1'b0) bad++;
    end
    n_total++; if (!ok || bad != 0) $display("FAIL nowd_hold: %0d bad cycles, want 0", bad); else n_pass++;
    req = '0;
  endtask
`endif

  task automatic test_random();
    logic [NUM_REQ-1:0] exp_grant;
    int shown;
    shown = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req  = NUM_REQ'($urandom_range(0, 3));
      done = ($urandom_range(0, 19) == 0) ? NUM_REQ'($urandom_range(1, 3)) : '0;
      if (tx_link_up ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
        tx_link_up = ~tx_link_up;
      tx_changing = ($urandom_range(0, 199) == 0);
      tx_reset    = ($urandom_range(0, 399) == 0);
      reset_n     = ($urandom_range(0, 699) != 0);
      step();
      exp_grant = '0;
      if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
      n_total++;
      if (grant !== exp_grant || grant_idx !== IW'(m_last) || busy !== (exp_grant != '0) || abort !== m_abort) begin
        if (shown < 8)
          $display("FAIL rand_cyc%0d: grant %b idx %0d busy %b abort %b want %b/%0d/%b/%b",
                   cyc, grant, grant_idx, busy, abort, exp_grant, m_last, exp_grant != '0, m_abort);
        shown++;
      end else n_pass++;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = '0; done = '0;
    tx_link_up = 1'b1; tx_changing = 1'b0; tx_reset = 1'b0;
    m_owner = -1; m_last = NUM_REQ - 1; m_pick_at = 0; m_age = 0; m_cycle = 0;
    m_blocked = 1'b1; m_blk_reg = 1'b1; m_abort = 1'b0;
    #2;
    test_reset();
    test_alternate();
    test_abort_change();
    test_done_linkdown();
    test_reset_mid_grant();
    test_rr_handoff();
`ifdef TX_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
